// File: rtl/cp0_timer_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, Cause bit positions, reset values.
package cp0_timer_ctrl_pkg;

  localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
  localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;

  localparam int unsigned CAUSE_TI_BIT  = 30;
  localparam int unsigned CAUSE_IP7_BIT = 15;

  // Nonzero so Count != Compare (reset 0) right after power-up.
  localparam logic [31:0] CP0_COUNT_RST = 32'h0000_0001;

  // Cause view of the timer: TI and IP7 both mirror the pending flag.
  function automatic logic [31:0] cause_timer_bits(input logic ip);
    logic [31:0] r;
    r                = '0;
    r[CAUSE_TI_BIT]  = ip;
    r[CAUSE_IP7_BIT] = ip;
    return r;
  endfunction

endpackage

// File: rtl/cp0_timer_ctrl_count_reg.sv
// CP0 Count register with DIV prescaler, software load and disable-count.
module cp0_count_reg
  import cp0_timer_ctrl_pkg::*;
#(
  parameter logic [31:0] COUNT_RST = CP0_COUNT_RST,
  parameter int unsigned DIV       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] ldata,
  input  logic        dc,
  output logic [31:0] count_q
);

  localparam logic [3:0] PRESC_LAST = 4'(DIV - 1);

  logic [3:0] presc;
  logic       tick;

  // Prescaler terminal count; frozen while dc is set.
  always_comb begin
    tick = !dc && (presc == PRESC_LAST);
  end

  // Count/prescaler update: reset, then load (beats dc), then enabled count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= COUNT_RST;
      presc   <= '0;
    end else if (load) begin
      count_q <= ldata;
      presc   <= '0;
    end else if (!dc) begin
      if (tick) begin
        presc   <= '0;
        count_q <= count_q + 32'd1;
      end else begin
        presc <= presc + 4'd1;
      end
    end
  end

endmodule

// File: rtl/cp0_timer_ctrl.sv
// CP0 timer: Count/Compare registers, match-edge pending flag, read mux.
module cp0_timer_ctrl
  import cp0_timer_ctrl_pkg::*;
#(
  parameter logic [31:0] COUNT_RST = CP0_COUNT_RST,
  parameter int unsigned DIV       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic        dc,
  input  logic        irq_en,
  output logic        timer_ip,
  output logic        timer_irq,
  output logic [31:0] count_q,
  output logic [31:0] compare_q
);

  logic count_we;
  logic compare_we;
  logic match;
  logic match_d;

  // Write decode and combinational match.
  always_comb begin
    count_we   = we && (waddr == CP0_REG_COUNT);
    compare_we = we && (waddr == CP0_REG_COMPARE);
    match      = (count_q == compare_q);
  end

  cp0_count_reg #(
    .COUNT_RST(COUNT_RST),
    .DIV      (DIV)
  ) u_count (
    .clk    (clk),
    .rst    (rst),
    .load   (count_we),
    .ldata  (wdata),
    .dc     (dc),
    .count_q(count_q)
  );

  // Compare register and pending flag; a Compare write clears pending and
  // forces match_d so the new value cannot fire until a fresh rising match.
  always_ff @(posedge clk) begin
    if (rst) begin
      compare_q <= '0;
      match_d   <= 1'b0;
      timer_ip  <= 1'b0;
    end else if (compare_we) begin
      compare_q <= wdata;
      match_d   <= 1'b1;
      timer_ip  <= 1'b0;
    end else begin
      match_d <= match;
      if (match && !match_d) begin
        timer_ip <= 1'b1;
      end
    end
  end

  // Interrupt request and registered-value read mux.
  always_comb begin
    timer_irq = timer_ip && irq_en;
    case (raddr)
      CP0_REG_COUNT:   rdata = count_q;
      CP0_REG_COMPARE: rdata = compare_q;
      CP0_REG_CAUSE:   rdata = cause_timer_bits(timer_ip);
      default:         rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_timer_ctrl.sv
// Self-checking bench for cp0_timer_ctrl (DIV=1 and DIV=4 instances).
module tb_cp0_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr = '0;
  logic        dc = 1'b0;
  logic        irq_en = 1'b0;

  logic [31:0] rdata, count_q, compare_q;
  logic        timer_ip, timer_irq;
  logic [31:0] rdata4, count4, compare4;
  logic        timer_ip4, timer_irq4;

  typedef struct {
    string       tag;
    bit          sel4;
    logic [31:0] count;
    logic [31:0] cmp;
    logic        ip;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cp0_timer_ctrl #(.COUNT_RST(32'h0000_0001), .DIV(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .dc(dc), .irq_en(irq_en),
    .timer_ip(timer_ip), .timer_irq(timer_irq),
    .count_q(count_q), .compare_q(compare_q)
  );

  cp0_timer_ctrl #(.COUNT_RST(32'h0000_0001), .DIV(4)) dut4 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata4), .dc(dc), .irq_en(irq_en),
    .timer_ip(timer_ip4), .timer_irq(timer_irq4),
    .count_q(count4), .compare_q(compare4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_write(input logic [4:0] a, input logic [31:0] d);
    we    = 1'b1;
    waddr = a;
    wdata = d;
  endtask

  task automatic push(input string tag, input bit sel4, input logic [31:0] c,
                      input logic [31:0] m, input logic ip, input logic irq);
    exp_t e;
    e.tag = tag; e.sel4 = sel4; e.count = c; e.cmp = m; e.ip = ip; e.irq = irq;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] gc, gm;
    irq_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rst = (i == 0);
      we  = 1'b0;
      push($sformatf("reset[%0d]", i), 0, 32'(i + 1), 32'h0, 1'b0, 1'b0);
      push($sformatf("reset4[%0d]", i), 1, 32'h1, 32'h0, 1'b0, 1'b0);
      step();
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        gc = e.sel4 ? count4 : count_q;
        gm = e.sel4 ? compare4 : compare_q;
        checks++; if (gc !== e.count) begin errors++; $display("FAIL %s count: got %h expected %h", e.tag, gc, e.count); end
        checks++; if (gm !== e.cmp) begin errors++; $display("FAIL %s compare: got %h expected %h", e.tag, gm, e.cmp); end
        if (!e.sel4) begin
          checks++; if (timer_ip !== e.ip) begin errors++; $display("FAIL %s timer_ip: got %b expected %b", e.tag, timer_ip, e.ip); end
          checks++; if (timer_irq !== e.irq) begin errors++; $display("FAIL %s timer_irq: got %b expected %b", e.tag, timer_irq, e.irq); end
        end
      end
    end
    raddr = 5'd9; #1;
    checks++; if (rdata !== 32'd4) begin errors++; $display("FAIL rd_count: got %h expected %h", rdata, 32'd4); end
    raddr = 5'd13; #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rd_cause_idle: got %h expected %h", rdata, 32'h0); end
  endtask

  task automatic test_compare_match();
    exp_t e;
    logic [31:0] ec[9];
    logic        eip[9];
    ec  = '{32'd5, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 32'd100};
    eip = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    irq_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      we = 1'b0;
      if (i == 0) set_write(5'd11, 32'd10);
      if (i == 1) set_write(5'd9, 32'd5);
      if (i == 8) set_write(5'd9, 32'd100);
      push($sformatf("match[%0d]", i), 0, ec[i], 32'd10, eip[i], eip[i]);
      step();
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++; if (count_q !== e.count) begin errors++; $display("FAIL %s count: got %h expected %h", e.tag, count_q, e.count); end
        checks++; if (compare_q !== e.cmp) begin errors++; $display("FAIL %s compare: got %h expected %h", e.tag, compare_q, e.cmp); end
        checks++; if (timer_ip !== e.ip) begin errors++; $display("FAIL %s timer_ip: got %b expected %b", e.tag, timer_ip, e.ip); end
        checks++; if (timer_irq !== e.irq) begin errors++; $display("FAIL %s timer_irq: got %b expected %b", e.tag, timer_irq, e.irq); end
      end
    end
    we = 1'b0;
  endtask

  task automatic test_wrap();
    exp_t e;
    logic [31:0] ec[7];
    logic        eip[7];
    ec  = '{32'd101, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h2, 32'h3};
    eip = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      we = 1'b0;
      if (i == 0) set_write(5'd11, 32'h0);
      if (i == 1) set_write(5'd9, 32'hFFFF_FFFE);
      if (i == 5) set_write(5'd11, 32'd100);
      push($sformatf("wrap[%0d]", i), 0, ec[i], (i >= 5) ? 32'd100 : 32'h0, eip[i], eip[i]);
      step();
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++; if (count_q !== e.count) begin errors++; $display("FAIL %s count: got %h expected %h", e.tag, count_q, e.count); end
        checks++; if (compare_q !== e.cmp) begin errors++; $display("FAIL %s compare: got %h expected %h", e.tag, compare_q, e.cmp); end
        checks++; if (timer_ip !== e.ip) begin errors++; $display("FAIL %s timer_ip: got %b expected %b", e.tag, timer_ip, e.ip); end
        checks++; if (timer_irq !== e.irq) begin errors++; $display("FAIL %s timer_irq: got %b expected %b", e.tag, timer_irq, e.irq); end
      end
    end
    we = 1'b0;
  endtask

  task automatic test_dc_div();
    exp_t e;
    logic [31:0] gc, gm;
    logic [31:0] d1[17];
    logic [31:0] d4[17];
    logic [31:0] cm;
    d1 = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd6, 32'd6, 32'd6,
           32'd50, 32'd50, 32'd50, 32'd51, 32'd52, 32'd53, 32'd54};
    d4 = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1,
           32'd50, 32'd50, 32'd50, 32'd50, 32'd50, 32'd50, 32'd51};
    for (int i = 0; i < 17; i++) begin
      we = 1'b0;
      dc = (i >= 7) && (i <= 12);
      if (i == 0)  set_write(5'd9, 32'd0);
      if (i == 8)  set_write(5'd11, 32'd200);
      if (i == 10) set_write(5'd9, 32'd50);
      cm = (i >= 8) ? 32'd200 : 32'd100;
      push($sformatf("dc[%0d]", i), 0, d1[i], cm, 1'b0, 1'b0);
      push($sformatf("div4[%0d]", i), 1, d4[i], cm, 1'b0, 1'b0);
      step();
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        gc = e.sel4 ? count4 : count_q;
        gm = e.sel4 ? compare4 : compare_q;
        checks++; if (gc !== e.count) begin errors++; $display("FAIL %s count: got %h expected %h", e.tag, gc, e.count); end
        checks++; if (gm !== e.cmp) begin errors++; $display("FAIL %s compare: got %h expected %h", e.tag, gm, e.cmp); end
        if (!e.sel4) begin
          checks++; if (timer_ip !== e.ip) begin errors++; $display("FAIL %s timer_ip: got %b expected %b", e.tag, timer_ip, e.ip); end
        end
      end
    end
    we = 1'b0;
    dc = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] ec[10];
    logic [31:0] em[10];
    logic        eip[10];
    logic        eirq[10];
    ec   = '{32'd55, 32'd18, 32'd19, 32'd20, 32'd21, 32'd299, 32'd300, 32'd301, 32'd302, 32'd303};
    em   = '{32'd20, 32'd20, 32'd20, 32'd20, 32'd300, 32'd300, 32'd300, 32'd300, 32'd300, 32'd300};
    eip  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    eirq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    irq_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      we = 1'b0;
      if (i == 0) set_write(5'd11, 32'd20);
      if (i == 1) set_write(5'd9, 32'd18);
      if (i == 4) set_write(5'd11, 32'd300);
      if (i == 5) begin irq_en = 1'b0; set_write(5'd9, 32'd299); end
      if (i == 8) set_write(5'd12, 32'd7);
      if (i == 9) irq_en = 1'b1;
      push($sformatf("b2b[%0d]", i), 0, ec[i], em[i], eip[i], eirq[i]);
      step();
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++; if (count_q !== e.count) begin errors++; $display("FAIL %s count: got %h expected %h", e.tag, count_q, e.count); end
        checks++; if (compare_q !== e.cmp) begin errors++; $display("FAIL %s compare: got %h expected %h", e.tag, compare_q, e.cmp); end
        checks++; if (timer_ip !== e.ip) begin errors++; $display("FAIL %s timer_ip: got %b expected %b", e.tag, timer_ip, e.ip); end
        checks++; if (timer_irq !== e.irq) begin errors++; $display("FAIL %s timer_irq: got %b expected %b", e.tag, timer_irq, e.irq); end
      end
      if (i == 7) begin
        raddr = 5'd13; #1;
        checks++; if (rdata !== 32'h4000_8000) begin errors++; $display("FAIL rd_cause: got %h expected %h", rdata, 32'h4000_8000); end
        raddr = 5'd11; #1;
        checks++; if (rdata !== 32'd300) begin errors++; $display("FAIL rd_compare: got %h expected %h", rdata, 32'd300); end
        raddr = 5'd5; #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rd_other: got %h expected %h", rdata, 32'h0); end
      end
    end
    we = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [31:0] gc, gm;
    logic [31:0] ec[7];
    logic [31:0] em[7];
    logic        eip[7];
    ec  = '{32'd304, 32'd497, 32'd498, 32'd499, 32'd500, 32'd1, 32'd2};
    em  = '{32'd498, 32'd498, 32'd498, 32'd498, 32'd498, 32'd0, 32'd0};
    eip = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    irq_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      we  = 1'b0;
      rst = (i == 5);
      if (i == 0) set_write(5'd11, 32'd498);
      if (i == 1) set_write(5'd9, 32'd497);
      if (i == 5) set_write(5'd9, 32'd77);
      push($sformatf("rstmid[%0d]", i), 0, ec[i], em[i], eip[i], eip[i]);
      if (i >= 5) push($sformatf("rstmid4[%0d]", i), 1, 32'd1, 32'd0, 1'b0, 1'b0);
      step();
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        gc = e.sel4 ? count4 : count_q;
        gm = e.sel4 ? compare4 : compare_q;
        checks++; if (gc !== e.count) begin errors++; $display("FAIL %s count: got %h expected %h", e.tag, gc, e.count); end
        checks++; if (gm !== e.cmp) begin errors++; $display("FAIL %s compare: got %h expected %h", e.tag, gm, e.cmp); end
        if (!e.sel4) begin
          checks++; if (timer_ip !== e.ip) begin errors++; $display("FAIL %s timer_ip: got %b expected %b", e.tag, timer_ip, e.ip); end
          checks++; if (timer_irq !== e.irq) begin errors++; $display("FAIL %s timer_irq: got %b expected %b", e.tag, timer_irq, e.irq); end
        end
      end
    end
    we  = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    test_reset();
    test_compare_match();
    test_wrap();
    test_dc_div();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
